// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB first, with a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_done;

   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   function automatic logic f_maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign w_s    = r_opa[0] ^ r_opb[0] ^ r_carry;
   assign w_c    = f_maj(r_opa[0], r_opb[0], r_carry);
   assign w_last = (r_cnt == LAST);

   generate
      if (WIDTH == 1) begin : g_res1
         assign w_res_nxt = w_s;
      end else begin : g_resn
         assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               // Subtraction is a + ~b + ~borrow through the same adder cell.
               r_opa   <= a;
               r_opb   <= sub ? ~b : b;
               r_carry <= sub ? ~cin : cin;
               r_cnt   <= '0;
            end
         end else begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
               // On the last bit r_carry is the carry into the MSB.
               r_sum  <= w_res_nxt;
               r_cout <= w_c;
               r_ovf  <= r_carry ^ w_c;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy     = (r_state == S_RUN);
   assign done     = r_done;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, expected
// results queued at start and compared when done pulses.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
   logic [0:0] a1, b1, sum1;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
   );

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Word-level reference for a w-bit add/subtract.
   function automatic exp_t model(input int w, input logic s, input logic [7:0] a,
                                  input logic [7:0] b, input logic c);
      exp_t       e;
      logic [7:0] m;
      logic [8:0] bb, full;
      logic       ci, sa, sb, sr;
      m    = 8'((9'd1 << w) - 9'd1);
      bb   = s ? {1'b0, ~b & m} : {1'b0, b & m};
      ci   = s ? ~c : c;
      full = {1'b0, a & m} + bb + {8'd0, ci};
      e.sum  = full[7:0] & m;
      e.cout = full[w];
      sa = a[w-1];
      sb = b[w-1];
      sr = e.sum[w-1];
      e.ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      e.cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
         else begin
            e = q8.pop_front();
            check("w8_sum", sum8, e.sum);
            check("w8_cout", cout8, e.cout);
            check("w8_ovf", ovf8, e.ovf);
            check("w8_done_cyc", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) check("w1_unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            check("w1_sum", sum1, e.sum);
            check("w1_cout", cout1, e.cout);
            check("w1_ovf", ovf1, e.ovf);
            check("w1_done_cyc", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
   task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
      exp_t e;
      start8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = c;
      e = model(8, s, a, b, c);
      e.cyc = cyc + 9;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
   endtask

   task automatic go1(input logic s, input logic a, input logic b, input logic c);
      exp_t e;
      start1 = 1'b1; sub1 = s; a1 = a; b1 = b; cin1 = c;
      e = model(1, s, {7'd0, a}, {7'd0, b}, c);
      e.cyc = cyc + 2;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait_done8(input int budget);
      int k = 0;
      while (!done8 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done8) check("w8_timeout", 0, 1);
   endtask

   task automatic wait_done1(input int budget);
      int k = 0;
      while (!done1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done1) check("w1_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);
      check("rst_ovf", ovf8, 0);
      check("rst_w1_busy", busy1, 0);
      check("rst_w1_sum", sum1, 0);
      rst = 1'b0;
      @(negedge clk);

      // Handshake timing on a plain add.
      go8(1'b0, 8'h3C, 8'h5A, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         check("t1_busy", busy8, 1);
         check("t1_done_early", done8, 0);
         @(negedge clk);
      end
      check("t1_busy_done_cycle", busy8, 0);
      check("t1_done", done8, 1);
      check("t1_sum_lit", sum8, 8'h96);
      check("t1_ovf_lit", ovf8, 1);
      @(negedge clk);
      check("t1_done_pulse", done8, 0);

      go8(1'b0, 8'hFF, 8'h01, 1'b1); wait_done8(20);
      go8(1'b1, 8'h10, 8'h20, 1'b0); wait_done8(20);
      go8(1'b1, 8'h80, 8'h01, 1'b0); wait_done8(20);
      go8(1'b1, 8'h05, 8'h05, 1'b1); wait_done8(20);

      // Start while busy is ignored; back-to-back start in the done cycle.
      go8(1'b0, 8'h11, 8'h22, 1'b0);
      repeat (3) @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(20);
      go8(1'b1, 8'h40, 8'h03, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         check("t4_hold_sum", sum8, 8'h33);
         @(negedge clk);
      end
      wait_done8(20);

      for (int n = 0; n < 12; n++) begin
         go8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         wait_done8(20);
      end

      // Reset in cycle 4 aborts the operation.
      go8(1'b0, 8'h7F, 8'h7F, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      q8.delete();
      check("t5_busy", busy8, 0);
      check("t5_done", done8, 0);
      check("t5_sum", sum8, 0);
      check("t5_cout", cout8, 0);
      check("t5_ovf", ovf8, 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      go8(1'b0, 8'h01, 8'h01, 1'b0);
      wait_done8(20);
      check("t5_sum_lit", sum8, 8'h02);

      // WIDTH=1 full-adder truth table.
      for (int i = 0; i < 8; i++) begin
         go1(1'b0, i[2], i[1], i[0]);
         wait_done1(10);
         check("t6_sum_lit", sum1, i[2] ^ i[1] ^ i[0]);
         @(negedge clk);
      end
      go1(1'b1, 1'b0, 1'b1, 1'b0); wait_done1(10);
      @(negedge clk);

      @(negedge clk);
      check("w8_queue_empty", q8.size(), 0);
      check("w1_queue_empty", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
